// File: rtl/req_pending_tracker_pkg.sv
// Shared definitions for the request pending tracker: default sizing and
// the per-requester count-update encoding.
package req_trk_pkg;

  localparam int unsigned N_DEF            = 4;
  localparam int unsigned CNT_W_DEF        = 3;
  localparam int unsigned AGE_W_DEF        = 8;
  localparam int unsigned STARVE_LIMIT_DEF = 16;

  // Count update chosen for one requester on one edge.
  // SAT means "wanted to increment but the count is already at max".
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2,
    SAT  = 2'd3
  } cnt_op_e;

  // A simultaneous request and retire cancel out, even at max, so that
  // case never reports a lost request.
  function automatic cnt_op_e cnt_op_sel(input logic inc, input logic dec,
                                         input logic at_max);
    cnt_op_e op;
    op = HOLD;
    if (inc && !dec) begin
      op = at_max ? SAT : INC;
    end else if (!inc && dec) begin
      op = DEC;
    end else begin
      op = HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/req_pending_slot.sv
// One requester of the pending tracker: saturating pending count, sticky
// overflow / spurious-grant flags and, when REQ_TRK_STARVE_EN is defined,
// an age counter that drives the starve flag. Without the macro no age
// state exists and starve is tied low.
module req_pending_slot
  import req_trk_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned AGE_W        = AGE_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_pulse,
  input  logic             gnt,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             req,
  output logic             ovf,
  output logic             spur_gnt,
  output logic             starve
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_q;
  logic             ovf_nxt;
  logic             spur_q;
  logic             spur_nxt;
  logic             nz;
  logic             dec;
  cnt_op_e          op;

  // Decide this edge's count update and the next sticky flag values.
  always_comb begin
    nz       = (cnt_q != CNT_ZERO);
    dec      = gnt & nz;
    op       = cnt_op_sel(req_pulse, dec, (cnt_q == CNT_MAX));
    cnt_nxt  = cnt_q;
    case (op)
      INC:     cnt_nxt = cnt_q + CNT_ONE;
      DEC:     cnt_nxt = cnt_q - CNT_ONE;
      SAT:     cnt_nxt = cnt_q;
      HOLD:    cnt_nxt = cnt_q;
      default: cnt_nxt = cnt_q;
    endcase
    // A set in the same cycle as the clear must survive.
    if (op == SAT) begin
      ovf_nxt = 1'b1;
    end else if (ovf_clr) begin
      ovf_nxt = 1'b0;
    end else begin
      ovf_nxt = ovf_q;
    end
    // A grant with nothing pending is dropped but remembered.
    if (gnt && !nz) begin
      spur_nxt = 1'b1;
    end else if (ovf_clr) begin
      spur_nxt = 1'b0;
    end else begin
      spur_nxt = spur_q;
    end
  end

  // Count and sticky-flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= CNT_ZERO;
      ovf_q  <= 1'b0;
      spur_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      ovf_q  <= ovf_nxt;
      spur_q <= spur_nxt;
    end
  end

  assign cnt      = cnt_q;
  assign req      = (cnt_q != CNT_ZERO);
  assign ovf      = ovf_q;
  assign spur_gnt = spur_q;

`ifdef REQ_TRK_STARVE_EN
  localparam logic [AGE_W-1:0] AGE_ZERO  = {AGE_W{1'b0}};
  localparam logic [AGE_W-1:0] AGE_ONE   = AGE_W'(1);
  localparam logic [AGE_W-1:0] AGE_MAX   = {AGE_W{1'b1}};
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] age_q;
  logic [AGE_W-1:0] age_nxt;
  logic             starve_q;
  logic             starve_nxt;

  // Age grows while something is pending and restarts on every retire or
  // when the slot empties; starve is registered from the next age value
  // so it moves on the same edge as the age itself.
  always_comb begin
    if (dec || (cnt_nxt == CNT_ZERO)) begin
      age_nxt = AGE_ZERO;
    end else if (nz && (age_q != AGE_MAX)) begin
      age_nxt = age_q + AGE_ONE;
    end else begin
      age_nxt = age_q;
    end
    starve_nxt = (age_nxt >= AGE_LIMIT);
  end

  // Age and starve registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      age_q    <= AGE_ZERO;
      starve_q <= 1'b0;
    end else begin
      age_q    <= age_nxt;
      starve_q <= starve_nxt;
    end
  end

  assign starve = starve_q;
`else
  assign starve = 1'b0;
`endif

endmodule

// File: rtl/req_pending_tracker.sv
// Request pending tracker: turns per-requester request pulses into level
// REQ lines for a fixed-priority arbiter and retires one pending request
// per returned GNT bit. Optional starvation detection is compiled in with
// the macro REQ_TRK_STARVE_EN; the port list is the same either way.
module req_pending_tracker
  import req_trk_pkg::*;
#(
  parameter int unsigned N            = N_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned AGE_W        = AGE_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req_pulse,
  input  logic [N-1:0]       GNT,
  input  logic               ovf_clr,
  output logic [N-1:0]       REQ,
  output logic [N*CNT_W-1:0] pend_cnt,
  output logic [N-1:0]       ovf,
  output logic [N-1:0]       spur_gnt,
  output logic [N-1:0]       starve
);

  // Requesters share nothing but the clock, reset and flag clear.
  for (genvar i = 0; i < N; i++) begin : g_slot
    logic [CNT_W-1:0] slot_cnt;

    req_pending_slot #(
      .CNT_W        (CNT_W),
      .AGE_W        (AGE_W),
      .STARVE_LIMIT (STARVE_LIMIT)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_pulse (req_pulse[i]),
      .gnt       (GNT[i]),
      .ovf_clr   (ovf_clr),
      .cnt       (slot_cnt),
      .req       (REQ[i]),
      .ovf       (ovf[i]),
      .spur_gnt  (spur_gnt[i]),
      .starve    (starve[i])
    );

    assign pend_cnt[i*CNT_W +: CNT_W] = slot_cnt;
  end

endmodule

// File: tb/tb_req_pending_tracker.sv
// Scoreboard bench for req_pending_tracker (N=4, CNT_W=3, STARVE_LIMIT=16).
// The driver applies one vector per cycle on the falling edge and queues the
// hand-computed state expected after the next rising edge; a monitor pops
// and compares shortly after every rising edge.
module tb_req_pending_tracker;

  localparam int unsigned N     = 4;
  localparam int unsigned CNT_W = 3;
`ifdef REQ_TRK_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       req_pulse;
  logic [N-1:0]       GNT;
  logic               ovf_clr;
  logic [N-1:0]       REQ;
  logic [N*CNT_W-1:0] pend_cnt;
  logic [N-1:0]       ovf;
  logic [N-1:0]       spur_gnt;
  logic [N-1:0]       starve;

  req_pending_tracker #(
    .N            (4),
    .CNT_W        (3),
    .AGE_W        (8),
    .STARVE_LIMIT (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_pulse (req_pulse),
    .GNT       (GNT),
    .ovf_clr   (ovf_clr),
    .REQ       (REQ),
    .pend_cnt  (pend_cnt),
    .ovf       (ovf),
    .spur_gnt  (spur_gnt),
    .starve    (starve)
  );

  typedef struct {
    string        tag;
    logic [3:0]   req;
    logic [11:0]  pc;
    logic [3:0]   ovf;
    logic [3:0]   spur;
    logic [3:0]   starve;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input string tag,
                     input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  // Monitor: compare DUT state after each edge against the queued entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("REQ",      e.tag, {8'd0, REQ},      {8'd0, e.req});
        chk("pend_cnt", e.tag, pend_cnt,         e.pc);
        chk("ovf",      e.tag, {8'd0, ovf},      {8'd0, e.ovf});
        chk("spur_gnt", e.tag, {8'd0, spur_gnt}, {8'd0, e.spur});
        chk("starve",   e.tag, {8'd0, starve},   {8'd0, e.starve});
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the edge.
  task automatic step(input string tag, input logic rn, input logic [3:0] rp,
                      input logic [3:0] g, input logic clr,
                      input logic [2:0] c3, input logic [2:0] c2,
                      input logic [2:0] c1, input logic [2:0] c0,
                      input logic [3:0] e_ovf, input logic [3:0] e_spur,
                      input logic [3:0] e_starve);
    exp_t e;
    @(negedge clk);
    rst_n     = rn;
    req_pulse = rp;
    GNT       = g;
    ovf_clr   = clr;
    e.tag     = tag;
    e.req     = {(c3 != 3'd0), (c2 != 3'd0), (c1 != 3'd0), (c0 != 3'd0)};
    e.pc      = {c3, c2, c1, c0};
    e.ovf     = e_ovf;
    e.spur    = e_spur;
    e.starve  = e_starve;
    sbq.push_back(e);
  endtask

  initial begin
    logic [2:0] c;
    logic       st;
    int         waited;
    rst_n     = 1'b0;
    req_pulse = 4'd0;
    GNT       = 4'd0;
    ovf_clr   = 1'b0;

    // Reset state, with inputs active to show they are ignored.
    step("reset", 1'b0, 4'b1111, 4'b1111, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 4'd0, 4'd0);
    step("idle",  1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 4'd0, 4'd0);

    // Single request then its grant.
    step("req0",  1'b1, 4'b0001, 4'b0000, 1'b0, 3'd0, 3'd0, 3'd0, 3'd1, 4'd0, 4'd0, 4'd0);
    step("gnt0",  1'b1, 4'b0000, 4'b0001, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 4'd0, 4'd0);

    // Nine pulses on bit 2: saturate at 7, overflow from the 8th pulse.
    for (int k = 1; k <= 9; k++) begin
      c = (k >= 7) ? 3'd7 : 3'(k);
      step("sat2", 1'b1, 4'b0100, 4'b0000, 1'b0, 3'd0, c, 3'd0, 3'd0,
           (k >= 8) ? 4'b0100 : 4'b0000, 4'd0, 4'd0);
    end
    step("ovf_clr", 1'b1, 4'b0000, 4'b0000, 1'b1, 3'd0, 3'd7, 3'd0, 3'd0, 4'd0, 4'd0, 4'd0);
    // Inc and dec together at max: unchanged, no overflow.
    step("incdec_max", 1'b1, 4'b0100, 4'b0100, 1'b0, 3'd0, 3'd7, 3'd0, 3'd0, 4'd0, 4'd0, 4'd0);
    for (int k = 6; k >= 0; k--) begin
      step("drain2", 1'b1, 4'b0000, 4'b0100, 1'b0, 3'd0, 3'(k), 3'd0, 3'd0, 4'd0, 4'd0, 4'd0);
    end

    // Bit 1: build to 3, simultaneous inc+dec holds, grant alone decrements.
    step("c1_1", 1'b1, 4'b0010, 4'b0000, 1'b0, 3'd0, 3'd0, 3'd1, 3'd0, 4'd0, 4'd0, 4'd0);
    step("c1_2", 1'b1, 4'b0010, 4'b0000, 1'b0, 3'd0, 3'd0, 3'd2, 3'd0, 4'd0, 4'd0, 4'd0);
    step("c1_3", 1'b1, 4'b0010, 4'b0000, 1'b0, 3'd0, 3'd0, 3'd3, 3'd0, 4'd0, 4'd0, 4'd0);
    step("c1_both", 1'b1, 4'b0010, 4'b0010, 1'b0, 3'd0, 3'd0, 3'd3, 3'd0, 4'd0, 4'd0, 4'd0);
    step("c1_gnt", 1'b1, 4'b0000, 4'b0010, 1'b0, 3'd0, 3'd0, 3'd2, 3'd0, 4'd0, 4'd0, 4'd0);
    step("c1_gnt", 1'b1, 4'b0000, 4'b0010, 1'b0, 3'd0, 3'd0, 3'd1, 3'd0, 4'd0, 4'd0, 4'd0);
    step("c1_gnt", 1'b1, 4'b0000, 4'b0010, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 4'd0, 4'd0);

    // Spurious grant on bit 3; set beats a simultaneous clear; then clear.
    step("spur3", 1'b1, 4'b0000, 4'b1000, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 4'b1000, 4'd0);
    step("spur3_clr", 1'b1, 4'b0000, 4'b1000, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 4'b1000, 4'd0);
    step("clr_only", 1'b1, 4'b0000, 4'b0000, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 4'd0, 4'd0);

    // Starvation of bit 3 while bit 0 is serviced every cycle.
    step("load03", 1'b1, 4'b1001, 4'b0000, 1'b0, 3'd1, 3'd0, 3'd0, 3'd1, 4'd0, 4'd0, 4'd0);
    for (int j = 1; j <= 17; j++) begin
      st = STARVE_ON && (j >= 16);
      step("starve3", 1'b1, 4'b0001, 4'b0001, 1'b0, 3'd1, 3'd0, 3'd0, 3'd1,
           4'd0, 4'd0, {st, 3'b000});
    end
    step("gnt3", 1'b1, 4'b0000, 4'b1000, 1'b0, 3'd0, 3'd0, 3'd0, 3'd1, 4'd0, 4'd0, 4'd0);

    // All requesters nonzero, then reset for one edge clears everything.
    step("all1", 1'b1, 4'b1111, 4'b0000, 1'b0, 3'd1, 3'd1, 3'd1, 3'd2, 4'd0, 4'd0, 4'd0);
    step("all2", 1'b1, 4'b1111, 4'b1000, 1'b0, 3'd1, 3'd2, 3'd2, 3'd3, 4'd0, 4'd0, 4'd0);
    step("mid_rst", 1'b0, 4'b1111, 4'b0000, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 4'd0, 4'd0);
    step("post_rst", 1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 4'd0, 4'd0);

    // Let the monitor drain the queue, bounded.
    waited = 0;
    while (sbq.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
